// File: rtl/branch_resolution_unit_if.sv
// Branch predictor <-> resolution unit bus: fetch predictions, execute outcomes,
// predictor update, flush/redirect and statistics.
interface branch_resolution_unit_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              bru_pred_valid;
   logic              bru_pred_ready;
   logic [ADDR_W-1:0] bru_pred_pc;
   logic              bru_pred_taken;
   logic [ADDR_W-1:0] bru_pred_target;
   logic              bru_res_valid;
   logic              bru_res_taken;
   logic [ADDR_W-1:0] bru_res_target;
   logic              bru_upd_valid;
   logic [ADDR_W-1:0] bru_upd_pc;
   logic              bru_upd_taken;
   logic              bru_flush;
   logic [ADDR_W-1:0] bru_redirect_pc;
   logic              bru_empty;
   logic              bru_err;
   logic [CNT_W-1:0]  bru_branch_cnt;
   logic [CNT_W-1:0]  bru_mispred_cnt;

   modport master (
      output bru_pred_valid, bru_pred_pc, bru_pred_taken, bru_pred_target,
      output bru_res_valid, bru_res_taken, bru_res_target,
      input  bru_pred_ready, bru_upd_valid, bru_upd_pc, bru_upd_taken,
      input  bru_flush, bru_redirect_pc, bru_empty, bru_err,
      input  bru_branch_cnt, bru_mispred_cnt
   );

   modport slave (
      input  bru_pred_valid, bru_pred_pc, bru_pred_taken, bru_pred_target,
      input  bru_res_valid, bru_res_taken, bru_res_target,
      output bru_pred_ready, bru_upd_valid, bru_upd_pc, bru_upd_taken,
      output bru_flush, bru_redirect_pc, bru_empty, bru_err,
      output bru_branch_cnt, bru_mispred_cnt
   );
endinterface

// File: rtl/branch_resolution_unit.sv
// In-order branch resolution: queues predictions, checks them against execute
// outcomes, flushes/redirects on mispredict and feeds outcomes back to the predictor.
module branch_resolution_unit #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input logic                   bru_clk,
   input logic                   bru_rst_n,
   branch_resolution_unit_if.slave bus
);
   localparam int                PW      = $clog2(DEPTH);
   localparam logic [PW:0]       DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_RECOVER = 1'b1} state_t;

   state_t            state_r;
   logic [PW-1:0]     head_r, tail_r;
   logic [PW:0]       count_r;
   logic [ADDR_W-1:0] pc_mem_r  [DEPTH];
   logic [ADDR_W-1:0] tgt_mem_r [DEPTH];
   logic              tkn_mem_r [DEPTH];

   logic              upd_valid_r, upd_taken_r, flush_r, err_r;
   logic [ADDR_W-1:0] upd_pc_r, redirect_pc_r;
   logic [CNT_W-1:0]  branch_cnt_r, mispred_cnt_r;

   logic              pred_ready_s, push_s, resolve_s, mispred_s, err_hit_s;
   logic [ADDR_W-1:0] head_pc_s, head_tgt_s, redirect_s;
   logic              head_tkn_s;

   // Handshake qualification and mispredict detection against the queue head.
   always_comb begin
      head_pc_s    = pc_mem_r[head_r];
      head_tgt_s   = tgt_mem_r[head_r];
      head_tkn_s   = tkn_mem_r[head_r];
      pred_ready_s = bru_rst_n && (state_r == ST_NORMAL) && (count_r < DEPTH_C);
      resolve_s    = bus.bru_res_valid && (state_r == ST_NORMAL) && (count_r != '0);
      err_hit_s    = bus.bru_res_valid && (state_r == ST_NORMAL) && (count_r == '0);
      if (resolve_s) begin
         mispred_s = (head_tkn_s != bus.bru_res_taken) ||
                     (head_tkn_s && bus.bru_res_taken && (head_tgt_s != bus.bru_res_target));
      end else begin
         mispred_s = 1'b0;
      end
      // Wrong-path pushes that coincide with a flush are discarded.
      push_s     = bus.bru_pred_valid && pred_ready_s && !mispred_s;
      redirect_s = bus.bru_res_taken ? bus.bru_res_target : head_pc_s + PC_STEP;
   end

   // Prediction storage; data only, validity is tracked by the pointers.
   always_ff @(posedge bru_clk) begin
      if (push_s) begin
         pc_mem_r[tail_r]  <= bus.bru_pred_pc;
         tgt_mem_r[tail_r] <= bus.bru_pred_target;
         tkn_mem_r[tail_r] <= bus.bru_pred_taken;
      end
   end

   // Queue control, recovery state, result pulses and statistics.
   always_ff @(posedge bru_clk) begin
      if (!bru_rst_n) begin
         state_r       <= ST_NORMAL;
         head_r        <= '0;
         tail_r        <= '0;
         count_r       <= '0;
         upd_valid_r   <= 1'b0;
         upd_pc_r      <= '0;
         upd_taken_r   <= 1'b0;
         flush_r       <= 1'b0;
         redirect_pc_r <= '0;
         err_r         <= 1'b0;
         branch_cnt_r  <= '0;
         mispred_cnt_r <= '0;
      end else begin
         upd_valid_r   <= resolve_s;
         upd_pc_r      <= resolve_s ? head_pc_s : '0;
         upd_taken_r   <= resolve_s && bus.bru_res_taken;
         flush_r       <= mispred_s;
         redirect_pc_r <= mispred_s ? redirect_s : '0;
         if (err_hit_s) begin
            err_r <= 1'b1;
         end
         if (resolve_s && (branch_cnt_r != CNT_MAX)) begin
            branch_cnt_r <= branch_cnt_r + CNT_W'(1);
         end
         if (mispred_s && (mispred_cnt_r != CNT_MAX)) begin
            mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
         end
         if (mispred_s) begin
            state_r <= ST_RECOVER;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
         end else begin
            state_r <= ST_NORMAL;
            if (push_s) begin
               tail_r <= tail_r + PW'(1);
            end
            if (resolve_s) begin
               head_r <= head_r + PW'(1);
            end
            case ({push_s, resolve_s})
               2'b10:   count_r <= count_r + (PW+1)'(1);
               2'b01:   count_r <= count_r - (PW+1)'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   assign bus.bru_pred_ready  = pred_ready_s;
   assign bus.bru_empty       = (count_r == '0);
   assign bus.bru_upd_valid   = upd_valid_r;
   assign bus.bru_upd_pc      = upd_pc_r;
   assign bus.bru_upd_taken   = upd_taken_r;
   assign bus.bru_flush       = flush_r;
   assign bus.bru_redirect_pc = redirect_pc_r;
   assign bus.bru_err         = err_r;
   assign bus.bru_branch_cnt  = branch_cnt_r;
   assign bus.bru_mispred_cnt = mispred_cnt_r;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed test of branch_resolution_unit: hit/miss resolution, redirect wrap,
// full-queue backpressure, FIFO order across pointer wrap, error and reset.
module tb_branch_resolution_unit;
   logic bru_clk = 1'b0;
   logic bru_rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   branch_resolution_unit_if #(.ADDR_W(32), .CNT_W(16)) bif ();

   branch_resolution_unit #(.ADDR_W(32), .DEPTH(4), .CNT_W(16)) dut (
      .bru_clk  (bru_clk),
      .bru_rst_n(bru_rst_n),
      .bus      (bif)
   );

   always #5 bru_clk = ~bru_clk;

   task automatic tick();
      @(posedge bru_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt);
      bif.bru_pred_valid  = 1'b1;
      bif.bru_pred_pc     = pc;
      bif.bru_pred_taken  = tkn;
      bif.bru_pred_target = tgt;
   endtask

   task automatic resolve(input logic tkn, input logic [31:0] tgt);
      bif.bru_res_valid  = 1'b1;
      bif.bru_res_taken  = tkn;
      bif.bru_res_target = tgt;
   endtask

   function automatic logic [31:0] pc_of(input int i);
      return 32'h3000 + 32'(4 * i);
   endfunction

   initial begin
      bif.bru_pred_valid = 1'b0; bif.bru_pred_pc = 32'h0; bif.bru_pred_taken = 1'b0;
      bif.bru_pred_target = 32'h0; bif.bru_res_valid = 1'b0; bif.bru_res_taken = 1'b0;
      bif.bru_res_target = 32'h0;

      // 1. reset values
      tick(); tick();
      chk("rst_upd_valid", 64'(bif.bru_upd_valid), 64'd0);
      chk("rst_upd_pc", 64'(bif.bru_upd_pc), 64'd0);
      chk("rst_flush", 64'(bif.bru_flush), 64'd0);
      chk("rst_redirect", 64'(bif.bru_redirect_pc), 64'd0);
      chk("rst_empty", 64'(bif.bru_empty), 64'd1);
      chk("rst_err", 64'(bif.bru_err), 64'd0);
      chk("rst_bcnt", 64'(bif.bru_branch_cnt), 64'd0);
      chk("rst_mcnt", 64'(bif.bru_mispred_cnt), 64'd0);
      chk("rst_ready", 64'(bif.bru_pred_ready), 64'd0);
      bru_rst_n = 1'b1;
      #1;
      chk("rel_ready", 64'(bif.bru_pred_ready), 64'd1);

      // 2. correct taken prediction
      push(32'h100, 1'b1, 32'h200); tick();
      bif.bru_pred_valid = 1'b0;
      resolve(1'b1, 32'h200); tick();
      bif.bru_res_valid = 1'b0;
      chk("hit_upd_valid", 64'(bif.bru_upd_valid), 64'd1);
      chk("hit_upd_pc", 64'(bif.bru_upd_pc), 64'h100);
      chk("hit_upd_taken", 64'(bif.bru_upd_taken), 64'd1);
      chk("hit_flush", 64'(bif.bru_flush), 64'd0);
      chk("hit_bcnt", 64'(bif.bru_branch_cnt), 64'd1);
      chk("hit_empty", 64'(bif.bru_empty), 64'd1);

      // 3. direction mispredict with a younger entry queued
      push(32'h100, 1'b0, 32'h0); tick();
      push(32'h104, 1'b1, 32'h500); tick();
      bif.bru_pred_valid = 1'b0;
      chk("q2_empty", 64'(bif.bru_empty), 64'd0);
      resolve(1'b1, 32'h300); tick();
      bif.bru_res_valid = 1'b0;
      chk("mis_flush", 64'(bif.bru_flush), 64'd1);
      chk("mis_redirect", 64'(bif.bru_redirect_pc), 64'h300);
      chk("mis_upd_pc", 64'(bif.bru_upd_pc), 64'h100);
      chk("mis_empty", 64'(bif.bru_empty), 64'd1);
      chk("mis_mcnt", 64'(bif.bru_mispred_cnt), 64'd1);
      chk("mis_bcnt", 64'(bif.bru_branch_cnt), 64'd2);
      chk("recover_ready", 64'(bif.bru_pred_ready), 64'd0);
      tick();
      chk("post_ready", 64'(bif.bru_pred_ready), 64'd1);
      chk("post_flush", 64'(bif.bru_flush), 64'd0);
      chk("post_upd_valid", 64'(bif.bru_upd_valid), 64'd0);
      chk("post_redirect", 64'(bif.bru_redirect_pc), 64'd0);

      // 4. predicted taken, actually not taken -> fall-through, incl. wrap
      push(32'h10, 1'b1, 32'h40); tick();
      bif.bru_pred_valid = 1'b0;
      resolve(1'b0, 32'h999); tick();
      bif.bru_res_valid = 1'b0;
      chk("nt_flush", 64'(bif.bru_flush), 64'd1);
      chk("nt_redirect", 64'(bif.bru_redirect_pc), 64'h14);
      chk("nt_upd_taken", 64'(bif.bru_upd_taken), 64'd0);
      tick();
      push(32'hFFFF_FFFC, 1'b1, 32'h8); tick();
      bif.bru_pred_valid = 1'b0;
      resolve(1'b0, 32'h0); tick();
      bif.bru_res_valid = 1'b0;
      chk("wrap_flush", 64'(bif.bru_flush), 64'd1);
      chk("wrap_redirect", 64'(bif.bru_redirect_pc), 64'h0);
      tick();
      // both taken, wrong target
      push(32'h20, 1'b1, 32'h80); tick();
      bif.bru_pred_valid = 1'b0;
      resolve(1'b1, 32'h84); tick();
      bif.bru_res_valid = 1'b0;
      chk("tgt_flush", 64'(bif.bru_flush), 64'd1);
      chk("tgt_redirect", 64'(bif.bru_redirect_pc), 64'h84);
      chk("tgt_mcnt", 64'(bif.bru_mispred_cnt), 64'd4);
      chk("tgt_bcnt", 64'(bif.bru_branch_cnt), 64'd5);
      tick();

      // 5. fill, blocked push during correct resolve, then drain in order
      for (int i = 0; i < 4; i++) begin
         push(32'h1000 + 32'(4 * i), 1'b0, 32'h0); tick();
      end
      chk("full_ready", 64'(bif.bru_pred_ready), 64'd0);
      push(32'h2000, 1'b0, 32'h0);
      resolve(1'b0, 32'hDEAD); tick();
      bif.bru_pred_valid = 1'b0;
      bif.bru_res_valid = 1'b0;
      chk("full_upd_pc", 64'(bif.bru_upd_pc), 64'h1000);
      chk("full_flush", 64'(bif.bru_flush), 64'd0);
      for (int j = 1; j < 4; j++) begin
         resolve(1'b0, 32'h0); tick();
         chk("drain_upd_pc", 64'(bif.bru_upd_pc), 64'(32'h1000 + 32'(4 * j)));
      end
      bif.bru_res_valid = 1'b0;
      chk("drain_empty", 64'(bif.bru_empty), 64'd1);
      // 10 branches, 3 in flight, concurrent push+resolve across pointer wrap
      for (int i = 0; i < 3; i++) begin
         push(pc_of(i), i[0], 32'h4000 + 32'(i)); tick();
      end
      for (int i = 3; i < 13; i++) begin
         if (i < 10) push(pc_of(i), i[0], 32'h4000 + 32'(i));
         else bif.bru_pred_valid = 1'b0;
         resolve((i - 3) % 2 == 1, 32'h4000 + 32'(i - 3)); tick();
         chk("fifo_upd_pc", 64'(bif.bru_upd_pc), 64'(pc_of(i - 3)));
         chk("fifo_upd_taken", 64'(bif.bru_upd_taken), 64'((i - 3) % 2));
         chk("fifo_flush", 64'(bif.bru_flush), 64'd0);
      end
      bif.bru_res_valid = 1'b0;
      chk("fifo_empty", 64'(bif.bru_empty), 64'd1);
      chk("fifo_bcnt", 64'(bif.bru_branch_cnt), 64'd19);
      chk("fifo_mcnt", 64'(bif.bru_mispred_cnt), 64'd4);

      // 6. resolve while empty, then reset with entries queued
      resolve(1'b1, 32'h0); tick();
      bif.bru_res_valid = 1'b0;
      chk("err_set", 64'(bif.bru_err), 64'd1);
      chk("err_no_upd", 64'(bif.bru_upd_valid), 64'd0);
      chk("err_bcnt", 64'(bif.bru_branch_cnt), 64'd19);
      tick();
      chk("err_sticky", 64'(bif.bru_err), 64'd1);
      push(32'h500, 1'b0, 32'h0); tick();
      push(32'h504, 1'b1, 32'h600); tick();
      bif.bru_pred_valid = 1'b0;
      chk("pre_rst_empty", 64'(bif.bru_empty), 64'd0);
      resolve(1'b1, 32'h700);
      bru_rst_n = 1'b0; tick();
      bif.bru_res_valid = 1'b0;
      chk("mid_rst_empty", 64'(bif.bru_empty), 64'd1);
      chk("mid_rst_upd", 64'(bif.bru_upd_valid), 64'd0);
      chk("mid_rst_flush", 64'(bif.bru_flush), 64'd0);
      chk("mid_rst_err", 64'(bif.bru_err), 64'd0);
      chk("mid_rst_bcnt", 64'(bif.bru_branch_cnt), 64'd0);
      bru_rst_n = 1'b1; tick();
      chk("after_rst_upd", 64'(bif.bru_upd_valid), 64'd0);
      chk("after_rst_empty", 64'(bif.bru_empty), 64'd1);
      chk("after_rst_ready", 64'(bif.bru_pred_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
